// File: rtl/intr_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states,
// core-facing trap constants and the priority helper.
package intr_ctrl_pkg;

    localparam logic [2:0] OFF_PENDING  = 3'd0;
    localparam logic [2:0] OFF_ENABLE   = 3'd1;
    localparam logic [2:0] OFF_EDGE     = 3'd2;
    localparam logic [2:0] OFF_CLAIM    = 3'd3;
    localparam logic [2:0] OFF_COMPLETE = 3'd4;

    localparam logic [31:0] NO_CLAIM    = 32'hFFFF_FFFF;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0010;  // core trap entry word address
    localparam int          TRAP_LEVEL  = 1;              // trap line is active high

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    // Lowest set bit wins: source 0 has the highest priority.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        lowest_set = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = 5'(i);
        end
    endfunction

endpackage

// File: rtl/intr_sync.sv
// Two-flop synchronizer bringing the asynchronous irq lines into the clk domain.
module intr_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // NOTE: every signal written here is assigned unconditionally, so no latch is inferred.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // NOTE: non-blocking assignments make both stages update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/intr_ctrl.sv
// Memory-mapped interrupt controller: pending/enable/edge registers, claim and
// complete handshake, and a registered trap request to the core.
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int          N_SRC     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             strobe,
    input  logic             rw,
    input  logic [31:0]      addr,
    input  logic [31:0]      d_in,
    output logic [31:0]      d_out,
    output logic             hit,
    output logic             trap
);

    logic [N_SRC-1:0] irq_sync;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] edge_sel_q, edge_sel_d;
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [1:0]       warm_q, warm_d;
    logic [4:0]       active_q, active_d;
    state_e           state_q, state_d;
    logic             trap_q, trap_d;

    logic [31:0]      rel_addr;
    logic [2:0]       offset;
    logic             rd_en, wr_en;
    logic [N_SRC-1:0] wdata, masked, edge_evt, clr_mask;
    logic             any_masked, claim_take;
    logic [4:0]       claim_id;
    logic             unused_d_in;

    intr_sync #(.WIDTH(N_SRC)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (irq_in),
        .q     (irq_sync)
    );

    // Unsigned wrap makes addresses below BASE_ADDR fall outside the window.
    assign rel_addr    = addr - BASE_ADDR;
    assign hit         = (rel_addr <= 32'd4);
    assign offset      = rel_addr[2:0];
    assign rd_en       = strobe && !rw && hit;
    assign wr_en       = strobe && rw && hit;
    assign wdata       = d_in[N_SRC-1:0];
    assign unused_d_in = ^d_in[31:N_SRC];

    assign masked     = pending_q & enable_q;
    assign any_masked = |masked;
    assign claim_id   = lowest_set(32'(masked));
    assign claim_take = rd_en && (offset == OFF_CLAIM) && (state_q != ST_SERVICE) && any_masked;

    // Edges are ignored until the synchronizer holds real post-reset samples.
    assign edge_evt = irq_sync & ~prev_q & {N_SRC{warm_q == 2'd3}};

    always_comb begin
        d_out = '0;
        if (rd_en) begin
            case (offset)
                OFF_PENDING: d_out = 32'(pending_q);
                OFF_ENABLE:  d_out = 32'(enable_q);
                OFF_EDGE:    d_out = 32'(edge_sel_q);
                OFF_CLAIM: begin
                    if (state_q == ST_SERVICE) d_out = 32'(active_q);
                    else if (any_masked)       d_out = 32'(claim_id);
                    else                       d_out = NO_CLAIM;
                end
                default:     d_out = '0;
            endcase
        end
    end

    always_comb begin
        clr_mask = '0;
        if (wr_en && (offset == OFF_PENDING)) clr_mask = wdata;
        if (claim_take) clr_mask = clr_mask | (N_SRC'(1) << claim_id);

        // Set beats clear on edge sources; level sources simply follow the line.
        pending_d  = (edge_sel_q & ((pending_q & ~clr_mask) | edge_evt))
                   | (~edge_sel_q & irq_sync);
        enable_d   = (wr_en && (offset == OFF_ENABLE)) ? wdata : enable_q;
        edge_sel_d = (wr_en && (offset == OFF_EDGE))   ? wdata : edge_sel_q;
        prev_d     = irq_sync;
        warm_d     = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        case (state_q)
            ST_IDLE, ST_REQ: begin
                if (claim_take) begin
                    state_d  = ST_SERVICE;
                    active_d = claim_id;
                end else begin
                    state_d = any_masked ? ST_REQ : ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (wr_en && (offset == OFF_COMPLETE) && (d_in[4:0] == active_q))
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        trap_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            enable_q   <= '0;
            edge_sel_q <= '0;
            prev_q     <= '0;
            warm_q     <= '0;
            active_q   <= '0;
            state_q    <= ST_IDLE;
            trap_q     <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            edge_sel_q <= edge_sel_d;
            prev_q     <= prev_d;
            warm_q     <= warm_d;
            active_q   <= active_d;
            state_q    <= state_d;
            trap_q     <= trap_d;
        end
    end

    assign trap = trap_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus random traffic,
// all outputs compared every cycle against a sample-history reference model.
module tb_intr_ctrl;

    localparam int          N    = 16;
    localparam logic [31:0] BASE = 32'h0000_0200;
    localparam int unsigned MASK = (1 << N) - 1;
    localparam int M_IDLE = 0, M_REQ = 1, M_SERV = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_in;
    logic          strobe, rw;
    logic [31:0]   addr, d_in, d_out;
    logic          hit, trap;

    intr_ctrl #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .strobe(strobe), .rw(rw),
        .addr(addr), .d_in(d_in), .d_out(d_out), .hit(hit), .trap(trap)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: registers as plain integers, the synchronizer as a history
    // of per-edge input samples, the controller mode as an integer.
    int unsigned m_pend, m_en, m_edg, m_act;
    int          m_mode;
    int          m_since;
    int unsigned hist[$];
    bit          chk_en = 1'b0;

    logic [N-1:0] cur_irq;
    logic [31:0]  obs_dout;
    logic         obs_trap, obs_hit;

    function automatic int lowest(input int unsigned v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] exp_dout();
        int unsigned rel = addr - BASE;
        int unsigned mk  = m_pend & m_en;
        if (!(strobe && !rw && rel <= 4)) return 32'h0;
        case (rel)
            0: return m_pend;
            1: return m_en;
            2: return m_edg;
            3: begin
                if (m_mode == M_SERV) return m_act;
                if (mk != 0) return 32'(lowest(mk));
                return 32'hFFFF_FFFF;
            end
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        int unsigned s2, pv, evt, rel, mk, clr, np;
        bit rd, wr, take;
        int id;
        if (reset) begin
            m_pend = 0; m_en = 0; m_edg = 0; m_act = 0;
            m_mode = M_IDLE; m_since = 0;
            hist = {32'd0, 32'd0, 32'd0};
            return;
        end
        m_since++;
        s2  = hist[hist.size()-2];   // sample taken two edges ago
        pv  = hist[hist.size()-3];   // sample taken three edges ago
        evt = (m_since >= 4) ? (s2 & ~pv) : 0;
        rel = addr - BASE;
        rd  = strobe && !rw && rel <= 4;
        wr  = strobe && rw && rel <= 4;
        mk  = m_pend & m_en;
        id  = lowest(mk);
        take = rd && rel == 3 && m_mode != M_SERV && mk != 0;
        clr = 0;
        if (wr && rel == 0) clr = d_in & MASK;
        if (take) clr |= (32'd1 << id);
        np = 0;
        for (int i = 0; i < N; i++) begin
            if (!m_edg[i])     np[i] = s2[i];
            else if (evt[i])   np[i] = 1'b1;
            else if (clr[i])   np[i] = 1'b0;
            else               np[i] = m_pend[i];
        end
        case (m_mode)
            M_SERV: if (wr && rel == 4 && d_in[4:0] == m_act[4:0]) m_mode = M_IDLE;
            default: begin
                if (take) begin m_mode = M_SERV; m_act = id; end
                else m_mode = (mk != 0) ? M_REQ : M_IDLE;
            end
        endcase
        m_pend = np;
        if (wr && rel == 1) m_en  = d_in & MASK;
        if (wr && rel == 2) m_edg = d_in & MASK;
        hist.push_back(32'(irq_in));
        if (hist.size() > 4) void'(hist.pop_front());
    endtask

    task automatic tick(input logic rst, input logic [N-1:0] irq, input logic stb,
                        input logic w, input logic [31:0] a, input logic [31:0] d);
        reset = rst; irq_in = irq; strobe = stb; rw = w; addr = a; d_in = d;
        @(negedge clk);
        obs_dout = d_out; obs_trap = trap; obs_hit = hit;
        if (chk_en) begin
            check("d_out", d_out, exp_dout());
            check("hit", 32'(hit), 32'((a - BASE) <= 32'd4));
            check("trap", 32'(trap), 32'(m_mode == M_REQ));
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, cur_irq, 1'b0, 1'b0, BASE + 32'd8, 32'h0);
    endtask

    task automatic wr_reg(input int off, input logic [31:0] v);
        tick(1'b0, cur_irq, 1'b1, 1'b1, BASE + 32'(off), v);
    endtask

    task automatic rd_reg(input int off, output logic [31:0] v);
        tick(1'b0, cur_irq, 1'b1, 1'b0, BASE + 32'(off), 32'h0);
        v = obs_dout;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, cur_irq, 1'b0, 1'b0, BASE + 32'd8, 32'h0);
    endtask

    task automatic wait_trap(input string tag, output int lat);
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (obs_trap) begin lat = i; break; end
        end
        check(tag, 32'(lat >= 0), 32'd1);
    endtask

    task automatic run_random(input int n);
        int b, off;
        logic rst, stb, w;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, N - 1);
                cur_irq[b] = ~cur_irq[b];
            end
            rst = ($urandom_range(0, 199) == 0);
            stb = ($urandom_range(0, 2) == 0);
            w   = 1'($urandom_range(0, 1));
            off = $urandom_range(0, 6);
            d   = $urandom;
            if ($urandom_range(0, 1) == 1) d[4:0] = m_act[4:0];
            tick(rst, cur_irq, stb, w, BASE - 32'd1 + 32'(off), d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int lat;
        cur_irq = '0;
        do_reset(1);
        chk_en = 1'b1;
        do_reset(2);
        check("rst_trap", 32'(obs_trap), 32'd0);
        rd_reg(0, v); check("rst_pending", v, 32'h0);
        rd_reg(1, v); check("rst_enable", v, 32'h0);
        rd_reg(2, v); check("rst_edge", v, 32'h0);
        idle(4);

        // Address window boundaries, with strobe low
        tick(1'b0, cur_irq, 1'b0, 1'b0, BASE - 32'd1, 32'h0); check("hit_below", 32'(obs_hit), 32'd0);
        tick(1'b0, cur_irq, 1'b0, 1'b0, BASE,         32'h0); check("hit_base",  32'(obs_hit), 32'd1);
        tick(1'b0, cur_irq, 1'b0, 1'b0, BASE + 32'd4, 32'h0); check("hit_top",   32'(obs_hit), 32'd1);
        tick(1'b0, cur_irq, 1'b0, 1'b0, BASE + 32'd5, 32'h0); check("hit_above", 32'(obs_hit), 32'd0);

        // Claim with nothing pending
        rd_reg(3, v); check("claim_empty", v, 32'hFFFF_FFFF);
        idle(1); check("empty_no_trap", 32'(obs_trap), 32'd0);

        // Single edge source 3: latency, claim, wrong complete
        wr_reg(1, 32'h8); wr_reg(2, 32'h8);
        tick(1'b0, 16'h0008, 1'b0, 1'b0, BASE + 32'd8, 32'h0);
        wait_trap("irq3_trap_seen", lat);
        check("irq3_latency", 32'(lat), 32'd3);
        rd_reg(3, v); check("claim3", v, 32'd3);
        idle(1); check("trap_low_after_claim", 32'(obs_trap), 32'd0);
        rd_reg(0, v); check("pend3_cleared", v & 32'h8, 32'h0);
        wr_reg(4, 32'd7); idle(2);
        check("wrong_complete_no_trap", 32'(obs_trap), 32'd0);
        rd_reg(3, v); check("claim_in_service", v, 32'd3);
        wr_reg(4, 32'd3); idle(2);

        // Priority between sources 5 and 2
        wr_reg(1, 32'h24); wr_reg(2, 32'h24);
        tick(1'b0, 16'h0024, 1'b0, 1'b0, BASE + 32'd8, 32'h0);
        wait_trap("prio_trap", lat);
        rd_reg(3, v); check("claim_prio_2", v, 32'd2);
        wr_reg(4, 32'd2);
        wait_trap("prio_retrap", lat);
        rd_reg(3, v); check("claim_prio_5", v, 32'd5);
        wr_reg(4, 32'd5); idle(2);

        // Level source 0
        wr_reg(2, 32'h0); wr_reg(1, 32'h1);
        cur_irq = 16'h0001;
        wait_trap("level_trap", lat);
        rd_reg(3, v); check("claim_level0", v, 32'd0);
        wr_reg(0, 32'h1);
        rd_reg(0, v); check("level_w1c_ignored", v & 32'h1, 32'h1);
        wr_reg(4, 32'd0);
        wait_trap("level_retrap", lat);
        rd_reg(3, v); check("claim_level0_again", v, 32'd0);
        cur_irq = '0; idle(4);
        wr_reg(4, 32'd0); idle(2);
        check("level_released", 32'(obs_trap), 32'd0);

        // Edge coinciding with W1C of the same bit: set wins
        wr_reg(1, 32'h0); wr_reg(2, 32'h2);
        tick(1'b0, 16'h0002, 1'b0, 1'b0, BASE + 32'd8, 32'h0);
        idle(1);
        wr_reg(0, 32'h2);
        rd_reg(0, v); check("w1c_race_set_wins", v & 32'h2, 32'h2);
        wr_reg(0, 32'h2);
        rd_reg(0, v); check("w1c_clears", v & 32'h2, 32'h0);

        // Reset during service with level source 4 high
        wr_reg(2, 32'h0); wr_reg(1, 32'h10);
        cur_irq = 16'h0010;
        wait_trap("svc_trap", lat);
        rd_reg(3, v); check("claim4", v, 32'd4);
        do_reset(2);
        rd_reg(0, v); check("rst_svc_pending", v, 32'h0);
        rd_reg(1, v); check("rst_svc_enable", v, 32'h0);
        rd_reg(2, v); check("rst_svc_edge", v, 32'h0);
        idle(5); check("rst_svc_no_trap", 32'(obs_trap), 32'd0);
        wr_reg(1, 32'h10);
        wait_trap("rst_svc_retrap", lat);
        rd_reg(3, v); check("claim4_after_rst", v, 32'd4);
        cur_irq = '0; idle(4);
        wr_reg(4, 32'd4); idle(2);

        // Input already high through reset must not look like an edge
        cur_irq = 16'h0040;
        do_reset(2);
        wr_reg(2, 32'h40);
        idle(6);
        rd_reg(0, v); check("no_false_edge", v & 32'h40, 32'h0);
        cur_irq = '0; idle(3);

        run_random(700);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
